// File: rtl/ptm_pkg.sv
// Shared definitions for the pattern-match logger: default widths and the
// run-control state encoding used by the logger, PTM and the bench.
package ptm_pkg;

    localparam int PTM_AW    = 10;
    localparam int PTM_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/ptm_addr_fifo.sv
// Synchronous first-word fall-through FIFO for match addresses. The clear
// input takes priority over push and pop. The head reads as zero when empty.
module ptm_addr_fifo
    import ptm_pkg::*;
#(
    parameter int AW    = PTM_AW,
    parameter int DEPTH = PTM_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [AW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees the head slot this edge, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale words are never visible because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ptm_match_log.sv
// Collects PTM match addresses for one run into a FIFO, counts matches and
// compares the count against PTM's own result total when the run finishes.
module ptm_match_log
    import ptm_pkg::*;
#(
    parameter int AW    = PTM_AW,
    parameter int DEPTH = PTM_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_en,
    input  logic [AW-1:0] in_addr,
    input  logic          in_flag,
    input  logic          in_fin,
    input  logic [AW-1:0] in_result,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic [AW:0]   match_cnt,
    output logic          overflow,
    output logic          done,
    output logic          mismatch
);

    localparam int CW = AW + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] match_cnt_q, match_cnt_d;
    logic          overflow_q, overflow_d;
    logic          mismatch_q, mismatch_d;

    logic          capture;
    logic          start_run;
    logic [CW-1:0] cnt_next;
    logic          fifo_full;
    logic          fifo_empty;

    assign capture   = (state_q == COLLECT) && in_en && in_flag;
    assign start_run = start && (state_q != COLLECT);
    assign cnt_next  = (capture && (match_cnt_q != '1)) ? match_cnt_q + CW'(1) : match_cnt_q;

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        overflow_d  = overflow_q;
        mismatch_d  = mismatch_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = COLLECT;
                    match_cnt_d = '0;
                    overflow_d  = 1'b0;
                    mismatch_d  = 1'b0;
                end
            end
            COLLECT: begin
                match_cnt_d = cnt_next;
                // Dropped only when full and no pop frees a slot this edge.
                if (capture && fifo_full && !rd_req) overflow_d = 1'b1;
                if (in_fin) begin
                    state_d    = DONE;
                    mismatch_d = (cnt_next != {1'b0, in_result});
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            overflow_q  <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            overflow_q  <= overflow_d;
            mismatch_q  <= mismatch_d;
        end
    end

    ptm_addr_fifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_run),
        .push      (capture),
        .push_data (in_addr),
        .pop       (rd_req),
        .pop_data  (rd_addr),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rd_valid  = !fifo_empty;
    assign match_cnt = match_cnt_q;
    assign overflow  = overflow_q;
    assign done      = (state_q == DONE);
    assign mismatch  = mismatch_q;

endmodule
